multi_debounce_pulse: RTL and testbench

MULTI_DEBOUNCE_PULSE -- requirements
Module: multi_debounce_pulse

---
 rtl/multi_debounce_pkg.sv | 20 ++
 rtl/db_channel.sv | 141 ++++++++++++++
 rtl/multi_debounce_pulse.sv | 66 ++++++
 tb/tb_multi_debounce_pulse.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/multi_debounce_pkg.sv
// Shared definitions for the multi-channel debouncer.
//   rpt_state_e : per-channel auto-repeat state (idle, initial delay, repeating)
//   cnt_width() : bit width needed to hold counts up to a given maximum
package multi_debounce_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDelay  = 2'd1,
        StRepeat = 2'd2
    } rpt_state_e;

    // Never returns less than 1, so degenerate maxima (0 or 1) still give a legal vector.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 2) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/db_channel.sv
// One debounce channel: 2-flop synchroniser, tick-based stability counter and auto-repeat FSM.
// Ports:
//   clk, rst_n  : system clock, synchronous active-low reset
//   i_tick      : shared sample tick, one clk wide
//   i_btn       : raw asynchronous button
//   i_rpt_en    : auto-repeat enable
//   o_level     : debounced level
//   o_rise      : one-clk pulse on debounced 0->1
//   o_fall      : one-clk pulse on debounced 1->0
//   o_press     : one-clk pulse on the press and on each auto-repeat
module db_channel
    import multi_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT   = 4,
    parameter int unsigned REPEAT_DELAY = 50,
    parameter int unsigned REPEAT_RATE  = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_btn,
    input  logic i_rpt_en,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_press
);

    localparam int unsigned STAB_W = cnt_width(STABLE_CNT);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W  = cnt_width(RPT_MAX);

    localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(STABLE_CNT - 1);
    localparam logic [RPT_W-1:0]  DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0]  RATE_LAST  = RPT_W'(REPEAT_RATE - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_level;
    logic              r_rise;
    logic              r_fall;
    logic              r_press;
    logic [STAB_W-1:0] r_stab;
    logic [RPT_W-1:0]  r_rpt_cnt;
    rpt_state_e        r_state;

    logic w_mismatch;
    logic w_flip;
    logic w_rise;
    logic w_fall;

    assign w_mismatch = r_sync2 ^ r_level;
    // Flip on the tick where the counter would reach STABLE_CNT.
    assign w_flip     = i_tick && w_mismatch && (r_stab == STAB_LAST);
    assign w_rise     = w_flip && !r_level;
    assign w_fall     = w_flip && r_level;

    // Synchroniser and stability counter; edge pulses register alongside the level update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_stab  <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_rise  <= w_rise;
            r_fall  <= w_fall;
            if (i_tick) begin
                if (!w_mismatch) begin
                    r_stab <= '0;
                end else if (w_flip) begin
                    r_stab  <= '0;
                    r_level <= ~r_level;
                end else begin
                    r_stab <= r_stab + STAB_W'(1);
                end
            end
        end
    end

    // Auto-repeat FSM; press is registered so it lines up with rise_pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_rpt_cnt <= '0;
            r_press   <= 1'b0;
        end else begin
            r_press <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_rise) begin
                        r_press   <= 1'b1;
                        r_rpt_cnt <= '0;
                        r_state   <= i_rpt_en ? StDelay : StIdle;
                    end
                end
                StDelay: begin
                    if (w_fall || !i_rpt_en) begin
                        r_state   <= StIdle;
                        r_rpt_cnt <= '0;
                    end else if (i_tick) begin
                        if (r_rpt_cnt == DELAY_LAST) begin
                            r_press   <= 1'b1;
                            r_rpt_cnt <= '0;
                            r_state   <= StRepeat;
                        end else begin
                            r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
                        end
                    end
                end
                StRepeat: begin
                    if (w_fall || !i_rpt_en) begin
                        r_state   <= StIdle;
                        r_rpt_cnt <= '0;
                    end else if (i_tick) begin
                        if (r_rpt_cnt == RATE_LAST) begin
                            r_press   <= 1'b1;
                            r_rpt_cnt <= '0;
                        end else begin
                            r_rpt_cnt <= r_rpt_cnt + RPT_W'(1);
                        end
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_rpt_cnt <= '0;
                end
            endcase
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;
    assign o_press = r_press;

endmodule

// File: rtl/multi_debounce_pulse.sv
// Multi-channel button debouncer with edge pulses and per-channel auto-repeat.
// Ports:
//   clk, rst_n  : system clock, synchronous active-low reset
//   btn_in      : raw asynchronous buttons, one bit per channel
//   rpt_en      : per-channel auto-repeat enable
//   level       : debounced levels
//   rise_pulse  : one-clk pulse on each debounced 0->1
//   fall_pulse  : one-clk pulse on each debounced 1->0
//   press       : one-clk pulse on each press and each auto-repeat
module multi_debounce_pulse
    import multi_debounce_pkg::*;
#(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned DIV          = 100000,
    parameter int unsigned STABLE_CNT   = 4,
    parameter int unsigned REPEAT_DELAY = 50,
    parameter int unsigned REPEAT_RATE  = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    input  logic [N_CH-1:0] rpt_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic [N_CH-1:0] press
);

    localparam int unsigned DIV_W = cnt_width(DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             w_tick;

    // With DIV=1 the counter sits at 0 and the tick is permanently high.
    assign w_tick = (r_div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        db_channel #(
            .STABLE_CNT  (STABLE_CNT),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_tick  (w_tick),
            .i_btn   (btn_in[gi]),
            .i_rpt_en(rpt_en[gi]),
            .o_level (level[gi]),
            .o_rise  (rise_pulse[gi]),
            .o_fall  (fall_pulse[gi]),
            .o_press (press[gi])
        );
    end

endmodule

// File: tb/tb_multi_debounce_pulse.sv
// Scoreboard bench for multi_debounce_pulse: a reference model pushes every expected output
// event into a queue; a negedge monitor pops and compares whenever the DUT shows activity.
module tb_multi_debounce_pulse;

    localparam int N_CH         = 2;
    localparam int DIV          = 4;
    localparam int STABLE_CNT   = 3;
    localparam int REPEAT_DELAY = 5;
    localparam int REPEAT_RATE  = 2;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic [N_CH-1:0] btn_in = '0;
    logic [N_CH-1:0] rpt_en = '0;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;
    logic [N_CH-1:0] press;

    multi_debounce_pulse #(
        .N_CH        (N_CH),
        .DIV         (DIV),
        .STABLE_CNT  (STABLE_CNT),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_in    (btn_in),
        .rpt_en    (rpt_en),
        .level     (level),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .press     (press)
    );

    always #5 clk = ~clk;

    typedef struct {
        int              edge_no;
        logic [N_CH-1:0] level;
        logic [N_CH-1:0] rise;
        logic [N_CH-1:0] fall;
        logic [N_CH-1:0] press;
    } ev_t;

    ev_t exp_q[$];
    int  checks  = 0;
    int  errors  = 0;
    int  edge_no = 0;

    // Reference model state, expressed in elapsed ticks and run lengths.
    int              m_since_rst;
    logic [N_CH-1:0] m_hist[$];
    int              m_run[N_CH];
    bit              m_lvl[N_CH];
    bit              m_active[N_CH];
    int              m_ticks[N_CH];
    logic [N_CH-1:0] m_prev_level = '0;

    always @(posedge clk) begin : model
        logic [N_CH-1:0] s;
        logic [N_CH-1:0] lv;
        logic [N_CH-1:0] ri;
        logic [N_CH-1:0] fa;
        logic [N_CH-1:0] pr;
        bit              tick;
        edge_no++;
        ri = '0;
        fa = '0;
        pr = '0;
        if (!rst_n) begin
            m_since_rst = 0;
            m_hist.delete();
            m_hist.push_back('0);
            m_hist.push_back('0);
            for (int c = 0; c < N_CH; c++) begin
                m_run[c]    = 0;
                m_lvl[c]    = 1'b0;
                m_active[c] = 1'b0;
                m_ticks[c]  = 0;
            end
        end else begin
            tick = ((m_since_rst % DIV) == DIV - 1);
            m_since_rst++;
            // Button value as seen two clocks ago.
            s = m_hist.pop_front();
            m_hist.push_back(btn_in);
            for (int c = 0; c < N_CH; c++) begin
                if (tick) begin
                    if (s[c] != m_lvl[c]) begin
                        m_run[c]++;
                        if (m_run[c] == STABLE_CNT) begin
                            m_lvl[c] = ~m_lvl[c];
                            m_run[c] = 0;
                            if (m_lvl[c]) ri[c] = 1'b1;
                            else          fa[c] = 1'b1;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
                if (ri[c]) begin
                    pr[c]       = 1'b1;
                    m_active[c] = rpt_en[c];
                    m_ticks[c]  = 0;
                end else if (m_active[c]) begin
                    if (fa[c] || !rpt_en[c]) begin
                        m_active[c] = 1'b0;
                    end else if (tick) begin
                        m_ticks[c]++;
                        if (m_ticks[c] == REPEAT_DELAY ||
                            (m_ticks[c] > REPEAT_DELAY &&
                             (m_ticks[c] - REPEAT_DELAY) % REPEAT_RATE == 0)) begin
                            pr[c] = 1'b1;
                        end
                    end
                end
            end
        end
        for (int c = 0; c < N_CH; c++) lv[c] = m_lvl[c];
        if ((ri | fa | pr) != '0 || lv != m_prev_level) begin
            exp_q.push_back('{edge_no, lv, ri, fa, pr});
        end
        m_prev_level = lv;
    end

    logic [N_CH-1:0] d_prev_level = '0;

    always @(negedge clk) begin : monitor
        ev_t e;
        bit  dut_ev;
        bit  exp_now;
        dut_ev  = ((rise_pulse | fall_pulse | press) !== '0) || (level !== d_prev_level);
        exp_now = (exp_q.size() > 0) && (exp_q[0].edge_no <= edge_no);
        if (dut_ev || exp_now) begin
            checks++;
            if (!exp_now) begin
                errors++;
                $display("FAIL sb_unexpected at edge %0d: actual level=%b rise=%b fall=%b press=%b, required no event",
                         edge_no, level, rise_pulse, fall_pulse, press);
            end else begin
                e = exp_q.pop_front();
                if (e.edge_no != edge_no || e.level !== level || e.rise !== rise_pulse ||
                    e.fall !== fall_pulse || e.press !== press) begin
                    errors++;
                    $display("FAIL sb_event at edge %0d: actual level=%b rise=%b fall=%b press=%b, required (edge %0d) level=%b rise=%b fall=%b press=%b",
                             edge_no, level, rise_pulse, fall_pulse, press,
                             e.edge_no, e.level, e.rise, e.fall, e.press);
                end
            end
        end
        d_prev_level = level;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        btn_in = '0;
        rpt_en = '0;
        cycles(3);
        #1;
        checks++;
        if ({level, rise_pulse, fall_pulse, press} !== '0) begin
            errors++;
            $display("FAIL reset_state: actual level=%b rise=%b fall=%b press=%b, required all 0",
                     level, rise_pulse, fall_pulse, press);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Short glitch: two ticks high must not change anything.
        btn_in[0] = 1'b1;
        cycles(2 * DIV);
        btn_in[0] = 1'b0;
        cycles(10 * DIV);

        // Held press with auto-repeat, then release.
        rpt_en    = 2'b01;
        btn_in[0] = 1'b1;
        cycles(24 * DIV);
        btn_in[0] = 1'b0;
        cycles(8 * DIV);

        // Both channels pressed on the same cycle.
        rpt_en = 2'b00;
        btn_in = 2'b11;
        cycles(8 * DIV);
        btn_in = 2'b00;
        cycles(8 * DIV);

        // Reset pulse while channel 0 is repeating.
        rpt_en = 2'b01;
        btn_in = 2'b01;
        cycles(15 * DIV);
        rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        cycles(10 * DIV);
        btn_in = 2'b00;
        cycles(8 * DIV);

        // Random bouncing, enable toggling and occasional resets.
        rpt_en = 2'b11;
        repeat (3000) begin
            if ($urandom_range(0, 29) == 0) btn_in[$urandom_range(0, N_CH - 1)] ^= 1'b1;
            if ($urandom_range(0, 199) == 0) rpt_en[$urandom_range(0, N_CH - 1)] ^= 1'b1;
            rst_n = ($urandom_range(0, 999) != 0);
            cycles(1);
        end
        rst_n  = 1'b1;
        btn_in = '0;
        rpt_en = '0;
        cycles(10 * DIV);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: actual %0d events left unmatched, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
